// File: rtl/pulse_evt_scheduler_pkg.sv
// pulse_evt_scheduler_pkg: shared FSM state encoding and timeout counter width
package pulse_evt_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BUSY = 2'd2} state_t;
  localparam int TMO_W = 16;
endpackage

// File: rtl/pulse_evt_scheduler_if.sv
// pulse_evt_scheduler_if: request/issue bundle between sources, scheduler and shared resource
// master (scheduler): in req_in, sched_en, issue_ready, issue_done, ovf_clr;
//                     out issue_valid, issue_id, busy, pending, ovf, timeout_pulse
// slave: mirror of master
interface pulse_evt_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
);
  logic [NUM_CH-1:0] req_in;
  logic [NUM_CH-1:0] ovf_clr;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ovf;
  logic              sched_en;
  logic              issue_ready;
  logic              issue_done;
  logic              issue_valid;
  logic              busy;
  logic              timeout_pulse;
  logic [ID_W-1:0]   issue_id;
  modport master (
    input  req_in, sched_en, issue_ready, issue_done, ovf_clr,
    output issue_valid, issue_id, busy, pending, ovf, timeout_pulse
  );
  modport slave (
    output req_in, sched_en, issue_ready, issue_done, ovf_clr,
    input  issue_valid, issue_id, busy, pending, ovf, timeout_pulse
  );
endinterface

// File: rtl/pulse_evt_scheduler_rr_pick.sv
// rr_pick: first set pending bit at or after ptr_i, wrapping modulo NUM_CH
// in pending_i, ptr_i; out any_o (some bit set), sel_o (chosen channel)
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] pending_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic              any_o,
  output logic [ID_W-1:0]   sel_o
);
  logic [NUM_CH-1:0] rot;
  logic [ID_W:0]     sum;
  // Rotate so bit 0 is ptr_i, take the lowest set offset, then map back with wrap.
  always_comb begin
    rot = NUM_CH'({pending_i, pending_i} >> ptr_i);
    sum = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) sum = {1'b0, ptr_i} + (ID_W+1)'(k);
    any_o = |pending_i;
    sel_o = sum >= (ID_W+1)'(NUM_CH) ? ID_W'(sum - (ID_W+1)'(NUM_CH)) : ID_W'(sum);
  end
endmodule

// File: rtl/pulse_evt_scheduler.sv
// pulse_evt_scheduler: serializes rising-edge request events onto one shared resource, round-robin
// clk, rst (sync, active-low); bus (master): req_in/ovf_clr/sched_en/issue_ready/issue_done in,
// issue_valid/issue_id/busy/pending/ovf/timeout_pulse out
module pulse_evt_scheduler
  import pulse_evt_scheduler_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 clk,
  input logic                 rst,
  pulse_evt_scheduler_if.master bus
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [NUM_CH-1:0] s1_q, s2_q, hist_q, edge_q, pending_q, ovf_q;
  logic [NUM_CH-1:0] pending_d, ovf_d, clr;
  logic [ID_W-1:0]   id_q, rr_q, sel;
  logic [TMO_W-1:0]  tmo_q;
  logic              valid_q, tp_q, any, hs;
  state_t            state_q;
  rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
    .pending_i(pending_q), .ptr_i(rr_q), .any_o(any), .sel_o(sel)
  );
  assign hs        = valid_q & bus.issue_ready;
  assign clr       = {NUM_CH{hs}} & (NUM_CH'(1) << id_q);
  // A new event beats the handshake clear; ovf only when the event is truly lost.
  assign pending_d = edge_q | (pending_q & ~clr);
  assign ovf_d     = (edge_q & pending_q & ~clr) | (ovf_q & ~bus.ovf_clr);
  // Edge is registered so a rise sampled at edge k reaches pending at edge k+3.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      hist_q    <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      s1_q      <= bus.req_in;
      s2_q      <= s1_q;
      hist_q    <= s2_q;
      edge_q    <= s2_q & ~hist_q;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      tp_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.sched_en && any) begin
          id_q    <= sel;
          valid_q <= 1'b1;
          state_q <= GRANT;
        end
        GRANT: if (bus.issue_ready) begin
          valid_q <= 1'b0;
          rr_q    <= id_q == ID_W'(NUM_CH - 1) ? '0 : id_q + 1'b1;
          tmo_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: if (bus.issue_done) state_q <= IDLE;
        else if (tmo_q == TMO_LAST) begin
          tp_q    <= 1'b1;
          state_q <= IDLE;
        end else tmo_q <= tmo_q + TMO_W'(tmo_q != '1);
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.issue_valid   = valid_q;
  assign bus.issue_id      = id_q;
  assign bus.busy          = state_q != IDLE;
  assign bus.pending       = pending_q;
  assign bus.ovf           = ovf_q;
  assign bus.timeout_pulse = tp_q;
endmodule

// File: tb/tb_pulse_evt_scheduler.sv
// tb_pulse_evt_scheduler: table vectors, directed sequences and random stimulus against a reference model
module tb_pulse_evt_scheduler;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pulse_evt_scheduler_if #(.NUM_CH(N), .ID_W(IW)) bus ();
  pulse_evt_scheduler #(.NUM_CH(N), .ID_W(IW), .TIMEOUT_CYC(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_bad = 0;
  logic [N-1:0] smp[$];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovf = '0;
  int m_phase = 0;
  int m_id = 0;
  int m_rr = 0;
  int m_cnt = 0;
  bit m_tp = 1'b0;
  typedef struct {
    logic r; logic [3:0] req; logic en, rdy, dn; logic [3:0] clr;
    logic v; logic [1:0] id; logic b; logic [3:0] p, o; logic tp;
  } vec_t;
  vec_t tbl[18];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: an event is a 0->1 step between consecutive samples, visible 3 edges later.
  task automatic model_step(input logic r, input logic [N-1:0] req, input logic en, input logic rdy,
                            input logic dn, input logic [N-1:0] clr);
    logic [N-1:0] evt, pold;
    bit hs, found, c;
    if (!r) begin
      smp.delete();
      repeat (5) smp.push_back('0);
      m_pend = '0; m_ovf = '0; m_phase = 0; m_id = 0; m_rr = 0; m_cnt = 0; m_tp = 1'b0;
      return;
    end
    smp.push_front(req);
    void'(smp.pop_back());
    evt = smp[3] & ~smp[4];
    pold = m_pend;
    hs = m_phase == 1 && rdy;
    for (int i = 0; i < N; i++) begin
      c = hs && m_id == i;
      m_ovf[i] = (evt[i] && pold[i] && !c) || (m_ovf[i] && !clr[i]);
      m_pend[i] = evt[i] || (pold[i] && !c);
    end
    m_tp = 1'b0;
    if (m_phase == 0) begin
      if (en && pold != 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++)
          if (!found && pold[(m_rr + k) % N]) begin
            found = 1'b1;
            m_id = (m_rr + k) % N;
          end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (rdy) begin
        m_rr = (m_id + 1) % N;
        m_cnt = 0;
        m_phase = 2;
      end
    end else begin
      if (dn) m_phase = 0;
      else if (m_cnt == T - 1) begin
        m_tp = 1'b1;
        m_phase = 0;
      end else m_cnt++;
    end
  endtask
  task automatic tick();
    logic r, en, rdy, dn;
    logic [N-1:0] req, clr;
    r = rst; req = bus.req_in; en = bus.sched_en; rdy = bus.issue_ready; dn = bus.issue_done; clr = bus.ovf_clr;
    @(posedge clk);
    model_step(r, req, en, rdy, dn, clr);
    #1;
    chk("m_valid", 32'(bus.issue_valid), 32'(m_phase == 1));
    chk("m_id", 32'(bus.issue_id), m_id);
    chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
    chk("m_pending", 32'(bus.pending), 32'(m_pend));
    chk("m_ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("m_tmo", 32'(bus.timeout_pulse), 32'(m_tp));
  endtask
  task automatic drive(input logic r, input logic [N-1:0] req, input logic en, input logic rdy,
                       input logic dn, input logic [N-1:0] clr);
    rst = r; bus.req_in = req; bus.sched_en = en; bus.issue_ready = rdy; bus.issue_done = dn; bus.ovf_clr = clr;
  endtask
  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask
  task automatic wait_valid(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      tick();
      ok = bus.issue_valid;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask
  task automatic collect(input int want, output int ids[$]);
    ids.delete();
    for (int c = 0; c < 40 && ids.size() < want; c++) begin
      tick();
      if (bus.issue_valid) ids.push_back(int'(bus.issue_id));
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int ids[$];
    int cnt, last, early;
    logic [N-1:0] rq;
    repeat (5) smp.push_back('0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
    for (int i = 3; i < 6; i++) tbl[i] = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[6] = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'hF, 4'h0, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[8] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
    for (int i = 9; i < 12; i++) tbl[i] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0, 1'b0};
    tbl[13] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 4'h4, 4'h0, 1'b0};
    tbl[14] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0, 1'b0};
    tbl[16] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0, 1'b0};
    // Reset hold and single event on ch2.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].req, tbl[i].en, tbl[i].rdy, tbl[i].dn, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d.valid", i), 32'(bus.issue_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d.id", i), 32'(bus.issue_id), 32'(tbl[i].id));
      chk($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d.pending", i), 32'(bus.pending), 32'(tbl[i].p));
      chk($sformatf("tbl%0d.ovf", i), 32'(bus.ovf), 32'(tbl[i].o));
      chk($sformatf("tbl%0d.tmo", i), 32'(bus.timeout_pulse), 32'(tbl[i].tp));
    end
    // Round-robin order 0,1,2,3 then 0,3.
    do_reset();
    bus.req_in = 4'hF;
    repeat (4) tick();
    chk("rr_pending_all", 32'(bus.pending), 32'hF);
    bus.sched_en = 1'b1; bus.issue_ready = 1'b1; bus.issue_done = 1'b1;
    collect(4, ids);
    chk("rr_count4", ids.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), k < ids.size() ? ids[k] : -1, k);
    bus.req_in = 4'h0;
    repeat (6) tick();
    bus.req_in = 4'h9;
    collect(2, ids);
    chk("rr_count2", ids.size(), 2);
    chk("rr_burst0", ids.size() > 0 ? ids[0] : -1, 0);
    chk("rr_burst1", ids.size() > 1 ? ids[1] : -1, 3);
    // Overflow on ch1 while scheduling is disabled.
    do_reset();
    bus.req_in = 4'h2;
    repeat (3) tick();
    bus.req_in = 4'h0;
    repeat (7) tick();
    bus.req_in = 4'h2;
    repeat (5) tick();
    chk("ovf_pending", 32'(bus.pending), 32'h2);
    chk("ovf_set", 32'(bus.ovf), 32'h2);
    bus.ovf_clr = 4'h2;
    tick();
    bus.ovf_clr = 4'h0;
    chk("ovf_cleared", 32'(bus.ovf), 32'h0);
    bus.sched_en = 1'b1; bus.issue_ready = 1'b1; bus.issue_done = 1'b1;
    cnt = 0; last = -1;
    repeat (15) begin
      tick();
      if (bus.issue_valid) begin cnt++; last = int'(bus.issue_id); end
    end
    chk("ovf_one_issue", cnt, 1);
    chk("ovf_issue_id", last, 1);
    chk("ovf_pending_done", 32'(bus.pending), 32'h0);
    // Timeout fires exactly T cycles after the handshake; done on that cycle suppresses it.
    do_reset();
    bus.sched_en = 1'b1; bus.issue_ready = 1'b1; bus.req_in = 4'h1;
    wait_valid("tmo_wait_grant");
    tick();
    chk("tmo_busy_hs", 32'(bus.busy), 32'd1);
    early = 0;
    repeat (T - 1) begin
      tick();
      if (bus.timeout_pulse) early++;
    end
    chk("tmo_no_early", early, 0);
    tick();
    chk("tmo_pulse", 32'(bus.timeout_pulse), 32'd1);
    chk("tmo_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("tmo_one_cycle", 32'(bus.timeout_pulse), 32'd0);
    bus.req_in = 4'h3;
    wait_valid("tmo_wait_grant2");
    chk("tmo_id2", 32'(bus.issue_id), 32'd1);
    tick();
    repeat (T - 1) tick();
    bus.issue_done = 1'b1;
    tick();
    bus.issue_done = 1'b0;
    chk("tmo_done_wins", 32'(bus.timeout_pulse), 32'd0);
    chk("tmo_done_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("tmo_done_nopulse", 32'(bus.timeout_pulse), 32'd0);
    // Backpressure holds the grant; a fresh edge in the handshake cycle keeps pending set.
    do_reset();
    bus.sched_en = 1'b1; bus.req_in = 4'h8;
    wait_valid("bp_wait_grant");
    for (int b = 1; b <= 5; b++) begin
      bus.req_in = b >= 3 ? 4'h8 : 4'h0;
      tick();
      chk($sformatf("bp_valid%0d", b), 32'(bus.issue_valid), 32'd1);
      chk($sformatf("bp_id%0d", b), 32'(bus.issue_id), 32'd3);
    end
    bus.issue_ready = 1'b1;
    tick();
    chk("col_valid", 32'(bus.issue_valid), 32'd0);
    chk("col_busy", 32'(bus.busy), 32'd1);
    chk("col_pending", 32'(bus.pending[3]), 32'd1);
    chk("col_ovf", 32'(bus.ovf[3]), 32'd0);
    // Random traffic against the model.
    rq = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      drive($urandom_range(199) != 0, rq, $urandom_range(9) != 0, $urandom_range(9) < 6,
            $urandom_range(3) == 0, N'($urandom_range(15) & $urandom_range(15) & $urandom_range(15)));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
